fa32_seq: RTL and testbench



---
 rtl/fa32_seq_pkg.sv | 12 +
 rtl/fa32_seq_fa32.sv | 14 +
 rtl/fa32_seq.sv | 148 ++++++++++++++
 tb/tb_fa32_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fa32_seq_pkg.sv
// Shared constants and FSM state encoding for the fa32_seq multi-precision adder.
package fa32_seq_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fa32_seq_state_t;

endpackage

// File: rtl/fa32_seq_fa32.sv
// Single 32-bit combinational full adder reused word by word by fa32_seq.
module fa32
    import fa32_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = (WORD_W+1)'(a) + (WORD_W+1)'(b) + (WORD_W+1)'(cin);

endmodule

// File: rtl/fa32_seq.sv
// Sequential WORDS x 32-bit adder, one word per cycle, LS word first.
// Optional subtract mode (sub port, B inverted, carry forced to 1) under `FA32_SEQ_SUB_EN.
module fa32_seq
    import fa32_seq_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = WORD_W * WORDS
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic            cin,
`ifdef FA32_SEQ_SUB_EN
    input  logic            sub,
`endif
    output logic            done_valid,
    input  logic            done_ready,
    output logic [W-1:0]    sum,
    output logic            cout,
    output logic            busy,
    output fa32_seq_state_t dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high. start_ready is high only in IDLE, done_valid only in DONE;
    // neither side's valid depends combinationally on the other side's ready.

    localparam int              IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    fa32_seq_state_t state_q, state_d;

    logic [WORDS-1:0][WORD_W-1:0] a_q;
    logic [WORDS-1:0][WORD_W-1:0] b_q;
    logic [WORDS-1:0][WORD_W-1:0] sum_q;
    logic                         carry_q;
    logic                         cout_q;
    logic [IDX_W-1:0]             idx_q;

    logic              accept;
    logic              step;
    logic              last;
    logic [W-1:0]      b_in;
    logic              carry_in;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;

    assign last = (idx_q == IDX_LAST);

    // Subtraction is a + ~b + 1; the inversion happens once, at capture.
    always_comb begin
        b_in     = b;
        carry_in = cin;
`ifdef FA32_SEQ_SUB_EN
        if (sub) begin
            b_in     = ~b;
            carry_in = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        step        = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done_valid = 1'b1;
                // A start_valid in this cycle is deliberately not taken.
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    fa32 u_fa32 (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= carry_in;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (step) begin
            sum_q[idx_q] <= add_sum;
            carry_q      <= add_cout;
            if (last) begin
                cout_q <= add_cout;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fa32_seq.sv
// Directed scoreboard bench for fa32_seq with WORDS=4 (sub cases under `FA32_SEQ_SUB_EN).
module tb_fa32_seq;
    import fa32_seq_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic            clk;
    logic            rst_n;
    logic            start_valid;
    logic            start_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            cin;
    logic            sub;
    logic            done_valid;
    logic            done_ready;
    logic [W-1:0]    sum;
    logic            cout;
    logic            busy;
    fa32_seq_state_t dbg_state;

    logic [W:0] exp_q[$];
    int         tests_run;
    int         tests_failed;

    fa32_seq #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
`ifdef FA32_SEQ_SUB_EN
        .sub         (sub),
`endif
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W:0] act, input logic [W:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every completed done handshake
    always @(negedge clk) begin
        if (rst_n && done_valid && done_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL result_unexpected: got %h expected none", {cout, sum});
            end else begin
                check("result", {cout, sum}, exp_q.pop_front());
            end
        end
    end

    // drivers
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                         input logic tsub, input bit push, input logic [W:0] exp);
        int waited;
        waited = 0;
        while (!start_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("start_ready_before_issue", (W+1)'(start_ready), (W+1)'(1));
        a           = ta;
        b           = tb_v;
        cin         = tcin;
        sub         = tsub;
        start_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        // operands must be private after the handshake
        a   = {$urandom, $urandom, $urandom, $urandom};
        b   = {$urandom, $urandom, $urandom, $urandom};
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        for (int cyc = 1; cyc <= WORDS; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < WORDS) begin
                check("done_valid_early", (W+1)'(done_valid), (W+1)'(0));
                check("start_ready_in_run", (W+1)'(start_ready), (W+1)'(0));
            end else begin
                check("done_valid_latency", (W+1)'(done_valid), (W+1)'(1));
                check("busy_in_done", (W+1)'(busy), (W+1)'(1));
            end
        end
    endtask

    task automatic retire();
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                          input logic tsub, input logic [W:0] exp);
        issue(ta, tb_v, tcin, tsub, 1'b1, exp);
        wait_done();
        retire();
    endtask

    logic [W-1:0] ones;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ones         = '1;
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        done_ready   = 1'b0;
        a            = '0;
        b            = '0;
        cin          = 1'b0;
        sub          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_start_ready", (W+1)'(start_ready), (W+1)'(1));
        check("reset_done_valid", (W+1)'(done_valid), (W+1)'(0));
        check("reset_busy", (W+1)'(busy), (W+1)'(0));
        check("reset_result", {cout, sum}, '0);
        check("reset_state", (W+1)'(dbg_state), (W+1)'(IDLE));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: zero operands
        run_op('0, '0, 1'b0, 1'b0, '0);
        // 2: carry ripples through every word
        run_op(ones, '0, 1'b1, 1'b0, {1'b1, {W{1'b0}}});
        // 3: carry out of word 0 into word 1
        run_op(128'h00000000_00000000_00000000_FFFFFFFF, 128'h1, 1'b0, 1'b0,
               {1'b0, 128'h00000000_00000000_00000001_00000000});
        // all ones plus all ones plus carry
        run_op(ones, ones, 1'b1, 1'b0, {1'b1, ones});

        // 4: hold result while new requests are offered
        issue(128'h1, 128'h2, 1'b1, 1'b0, 1'b1, 129'h4);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            a           = ones;
            b           = ones;
            cin         = 1'b1;
            @(posedge clk);
            #1;
            check("hold_result", {cout, sum}, 129'h4);
            check("hold_start_ready", (W+1)'(start_ready), (W+1)'(0));
            check("hold_done_valid", (W+1)'(done_valid), (W+1)'(1));
        end
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready  = 1'b0;
        start_valid = 1'b0;
        check("retire_no_accept_busy", (W+1)'(busy), (W+1)'(0));
        check("retire_done_valid", (W+1)'(done_valid), (W+1)'(0));
        check("result_kept_after_retire", {cout, sum}, 129'h4);
        run_op(128'h00000001_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0,
               {1'b0, 128'h00000002_00000000_00000000_00000000});

        // 5: reset in the middle of RUN discards the operation
        issue(128'h00000000_00000000_FFFFFFFF_FFFFFFFF, 128'h3, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_run_state", (W+1)'(dbg_state), (W+1)'(RUN));
        rst_n = 1'b0;
        #1;
        check("async_reset_done_valid", (W+1)'(done_valid), (W+1)'(0));
        check("async_reset_result", {cout, sum}, '0);
        check("async_reset_start_ready", (W+1)'(start_ready), (W+1)'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(128'h1, 128'h2, 1'b0, 1'b0, 129'h3);

`ifdef FA32_SEQ_SUB_EN
        // 6: subtraction, cout is the no-borrow flag
        run_op(128'h5, 128'h7, 1'b0, 1'b1, {1'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE});
        run_op(128'h7, 128'h5, 1'b0, 1'b1, {1'b1, 128'h2});
        run_op(128'h7, 128'h5, 1'b1, 1'b0, {1'b0, 128'hD});
`endif

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", (W+1)'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
